// File: rtl/cla_word_sequencer_pkg.sv
// Shared defaults and FSM encoding for the sliced carry-lookahead word adder.
package cla_word_sequencer_pkg;

  localparam int SLICE_W_DEF = 8;
  localparam int SLICES_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_slice_adder.sv
// Combinational SLICE_W-bit carry-lookahead slice; every carry is a flat
// sum-of-products of generate/propagate terms and the slice carry-in.
module cla_slice_adder #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               c_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o,
  output logic               cmsb_o
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   carry;
  logic               term;
  logic               prop;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // carry[i] = G[i-1] | P[i-1]G[i-2] | ... | P[i-1..0]c_i
  always_comb begin
    carry    = '0;
    term     = 1'b0;
    prop     = 1'b1;
    carry[0] = c_i;
    for (int i = 1; i <= SLICE_W; i++) begin
      term = 1'b0;
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      carry[i] = term | (prop & c_i);
    end
  end

  assign sum_o  = p ^ carry[SLICE_W-1:0];
  assign cout_o = carry[SLICE_W];
  assign cmsb_o = carry[SLICE_W-1];

endmodule

// File: rtl/cla_word_sequencer.sv
// Wide add/subtract built from one lookahead slice swept LSB-first, one slice
// per clock, with the inter-slice carry held in carry_q.
module cla_word_sequencer
  import cla_word_sequencer_pkg::*;
#(
  parameter  int SLICE_W = SLICE_W_DEF,
  parameter  int SLICES  = SLICES_DEF,
  localparam int WORD_W  = SLICE_W * SLICES,
  localparam int IDX_W   = (SLICES > 1) ? $clog2(SLICES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              ovf,
  output logic              busy,
  output logic [IDX_W-1:0]  slice_idx
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   a_q, b_q, sum_q;
  logic                carry_q, cout_q, ovf_q;
  logic [IDX_W-1:0]    idx_q;
  logic [SLICE_W-1:0]  sl_sum;
  logic                sl_cout, sl_cmsb;
  logic                last_slice;

  assign last_slice = (idx_q == IDX_W'(SLICES - 1));

  cla_slice_adder #(.SLICE_W(SLICE_W)) u_slice (
    .a_i    (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b_i    (b_q[idx_q*SLICE_W +: SLICE_W]),
    .c_i    (carry_q),
    .sum_o  (sl_sum),
    .cout_o (sl_cout),
    .cmsb_o (sl_cmsb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)        state_d = ST_RUN;
      ST_RUN:  if (last_slice)      state_d = ST_DONE;
      ST_DONE: if (out_ready)       state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    slice_idx = (state_q == ST_RUN) ? idx_q : '0;
  end

  // Subtraction is a + ~b + 1: invert b once at accept and seed the carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= sub ? 1'b1 : cin;
          sum_q   <= '0;
          idx_q   <= '0;
        end
        ST_RUN: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= sl_sum;
          carry_q <= sl_cout;
          if (last_slice) begin
            cout_q <= sl_cout;
            ovf_q  <= sl_cout ^ sl_cmsb;
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Scoreboarded bench: driver pushes expected results, negedge monitor pops and compares.
module tb_cla_word_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout, ovf, busy;
  logic [1:0]  slice_idx;

  int checks = 0;
  int failures = 0;
  bit rdy_rand = 0;
  bit force_hold = 0;

  typedef struct packed { logic [31:0] s; logic c; logic o; } res_t;
  res_t exp_q[$];

  cla_word_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .busy(busy), .slice_idx(slice_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic with a signed-sign rule for overflow.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
    logic [32:0] full;
    logic [31:0] yy;
    res_t r;
    yy   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {32'd0, (sb ? 1'b1 : ci)};
    r.s  = full[31:0];
    r.c  = full[32];
    r.o  = (x[31] == yy[31]) && (full[31] != x[31]);
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (force_hold)    out_ready = 1'b0;
    else if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    else               out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(sum), 64'hDEAD);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
        chk("ovf", 64'(ovf), 64'(e.o));
      end
    end
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic sb, input res_t e);
    int n = 0;
    @(posedge clk); #1;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'(n), 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    res_t e;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cout_ovf", 64'({cout, ovf, slice_idx}), 64'd0);
    rst_n = 1'b1;

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0});
    drain();

    // Full carry chain, plus slice_idx sequence and output latency.
    do_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, '{32'h0, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("slice_idx", 64'(slice_idx), 64'(k));
      chk("run_busy_noval", 64'({busy, out_valid, in_ready}), 64'b100);
    end
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    drain();

    do_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1});
    do_op(32'h5, 32'h7, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0});
    drain();

    // Backpressure: hold DONE for 5 cycles while a new operand is offered.
    force_hold = 1;
    @(posedge clk);
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{32'h2345_6789, 1'b0, 1'b0});
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_reach_done", 64'(out_valid), 64'd1);
    a = 32'hAAAA_AAAA; b = 32'h5; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum_stable", 64'(sum), 64'h2345_6789);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    force_hold = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_idle", 64'({in_ready, out_valid, busy}), 64'b100);
    drain();

    // Reset during RUN discards the partial result.
    do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_run_idx", 64'(slice_idx), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", 64'({in_ready, out_valid, busy, slice_idx}), 64'b10000);
    chk("midrst_res", 64'({sum, cout, ovf}), 64'd0);
    exp_q.delete();
    rst_n = 1'b1;
    do_op(32'd3, 32'd4, 1'b0, 1'b0, '{32'd7, 1'b0, 1'b0});
    drain();

    rdy_rand = 1;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] x, y;
      logic ci, sb;
      x  = $urandom;
      y  = (k % 5 == 0) ? ~x : $urandom;
      ci = 1'($urandom);
      sb = 1'($urandom);
      e  = model(x, y, ci, sb);
      do_op(x, y, ci, sb, e);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_word_sequencer.md
Name: cla_word_sequencer

Overview:
Multi-cycle wide adder/subtractor controller built around one SLICE_W-bit carry-lookahead slice. Accepts a WORD_W-bit operand pair on a valid/ready handshake and sequences the slice LSB-first, one slice per clock, registering the carry between slices. Returns sum, carry-out and signed overflow on a valid/ready output handshake. Used by the convolution accumulate path where a full-width adder is too costly in area/power.

Parameters:
SLICE_W, 8, width of the lookahead slice in bits
SLICES, 4, number of slices per word
WORD_W, SLICE_W*SLICES, operand/result width (derived, not overridable)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WORD_W  operand A
b  in  WORD_W  operand B
cin  in  1  carry-in (add mode only)
sub  in  1  1 = compute a - b, 0 = a + b + cin
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WORD_W  result
cout  out  1  carry out of MSB (subtract: 1 = no borrow)
ovf  out  1  signed overflow
busy  out  1  high in RUN or DONE
slice_idx  out  $clog2(SLICES) (min 1)  slice being computed in RUN, 0 otherwise

Behaviour:
- Clock is clk; reset is synchronous and active-low (rst_n), sampled on rising clk only.
- Reset values: state IDLE, in_ready 1, out_valid 0, sum 0, cout 0, ovf 0, busy 0, slice_idx 0, internal operand/carry registers 0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready: latch a into a_q; latch b (sub=0) or ~b (sub=1) into b_q; carry_q <= sub ? 1 : cin; sum <= 0; slice_idx <= 0; -> RUN.
- RUN: in_ready = 0. Each cycle the slice adds a_q/b_q bits [slice_idx*SLICE_W +: SLICE_W] with carry_q; result written to same bits of sum; carry_q <= slice carry out; slice_idx increments. When slice_idx == SLICES-1: cout <= slice carry out; ovf <= slice carry out XOR carry into slice MSB; slice_idx <= 0; -> DONE.
- DONE: out_valid = 1; sum/cout/ovf held stable. On out_ready -> IDLE (out_valid 0, in_ready 1 from next cycle; no same-cycle bypass of a new operand).
- Latency: accept edge at cycle T -> out_valid high from cycle T+SLICES+... exactly: RUN occupies SLICES cycles, out_valid asserted after edge T+SLICES. Throughput: one op per SLICES+2 cycles minimum (out_ready held high).
- Inputs a, b, cin, sub ignored outside the IDLE handshake cycle; changing them in RUN has no effect.
- out_ready outside DONE ignored. in_valid during RUN/DONE is not accepted (in_ready 0); producer must hold.
- rst_n low in any state, including mid-RUN or DONE with out_valid high: next edge returns to reset values; partial result discarded.
- Arithmetic: modulo 2^WORD_W; cout/ovf as above; sub mode result equals a + ~b + 1.

Decomposition:
- Shared package: SLICE_W, SLICES defaults; state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module: cla_slice_adder (SLICE_W-bit combinational lookahead slice: P = a^b, G = a&b, ripple-free carry chain, sum = P ^ carries; outputs sum, cout, carry into MSB). Controller holds all sequential logic.

Test Plan:
- Reset: rst_n low 2 cycles -> in_ready 1, out_valid 0, sum 0, busy 0.
- Add: a=32'h0000_00FF, b=32'h0000_0001, cin=0, sub=0 -> after 4 RUN cycles sum=32'h0000_0100, cout 0, ovf 0; carry propagates slice 0 -> 1.
- Full carry chain: a=32'hFFFF_FFFF, b=0, cin=1 -> sum=0, cout 1, ovf 0; slice_idx observed 0,1,2,3 during RUN.
- Subtract/overflow: a=32'h8000_0000, b=1, sub=1 -> sum=32'h7FFF_FFFF, cout 1, ovf 1; a=5, b=7, sub=1 -> sum=32'hFFFF_FFFE, cout 0, ovf 0.
- Backpressure: out_ready low 5 cycles in DONE -> out_valid/sum stable, in_ready 0, new in_valid not accepted; out_ready high -> IDLE next edge.
- Reset mid-RUN: assert rst_n low at slice_idx 2 -> next edge all outputs at reset values; following operation a=3,b=4 gives sum=7 unaffected.
